// File: rtl/ascon_serial_unloader.sv
`default_nettype none
// ============================================================================
// Module   : ascon_serial_unloader
// Purpose  : Transmit end of the Ascon decryption core's bit-serial pin
//            interface. Captures the plaintext and tag when the core strobes
//            load_validxSI, raises decryption_readyxSO, waits a fixed lead-in,
//            then shifts both words out LSB-first on two parallel lanes, one
//            bit per clock.
// Ports    : clk                 - clock, rising edge
//            rst                 - synchronous reset, active-low
//            plain_textxDI [y]   - plaintext from core
//            tagxDI        [T]   - tag from core
//            load_validxSI       - one-cycle "result ready" strobe
//            load_readyxSO       - unloader idle, strobe accepted
//            decryption_readyxSO - result held / being unloaded
//            plain_textxSO       - serial plaintext bit
//            tagxSO              - serial tag bit
//            bit_validxSO        - lanes carry a valid bit
//            bit_lastxSO         - final valid bit of the frame
// Config   : ASCON_SO_PARITY_EN  - when defined, one extra parity bit
//            (XOR of each captured word) closes every frame.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_serial_unloader #(
  parameter int y    = 80,
  parameter int T    = 128,
  parameter int LEAD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [y-1:0] plain_textxDI,
  input  logic [T-1:0] tagxDI,
  input  logic         load_validxSI,
  output logic         load_readyxSO,
  output logic         decryption_readyxSO,
  output logic         plain_textxSO,
  output logic         tagxSO,
  output logic         bit_validxSO,
  output logic         bit_lastxSO
);

  localparam int MAX  = (y >= T) ? y : T;
  // One counter serves both the lead-in and the shift phase.
  localparam int SPAN = (MAX >= LEAD) ? MAX : LEAD;
  localparam int CW   = $clog2(SPAN + 1);

  localparam logic [CW-1:0] c_leadEnd  = CW'(LEAD);
  localparam logic [CW-1:0] c_shiftEnd = CW'(MAX - 1);

  localparam logic [1:0] c_stIdle  = 2'd0;
  localparam logic [1:0] c_stLead  = 2'd1;
  localparam logic [1:0] c_stShift = 2'd2;
`ifdef ASCON_SO_PARITY_EN
  localparam logic [1:0] c_stPar   = 2'd3;
  localparam logic       c_parityEn = 1'b1;
`else
  localparam logic       c_parityEn = 1'b0;
`endif

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [y-1:0]  r_ptShadow;
  logic [T-1:0]  r_tagShadow;
`ifdef ASCON_SO_PARITY_EN
  logic          r_ptPar;
  logic          r_tagPar;
`endif

  // The lead-in state lasts LEAD+1 cycles (the first one is the cycle right
  // after capture). Its final edge launches bit 0; each non-final SHIFT edge
  // launches the next bit, so r_cnt in SHIFT equals the index on the lanes.
  logic          w_emit;
  logic [CW-1:0] w_emitIdx;
  logic          w_emitLast;

  always_comb begin
    w_emit    = 1'b0;
    w_emitIdx = '0;
    if (r_state == c_stLead && r_cnt == c_leadEnd) begin
      w_emit = 1'b1;
    end else if (r_state == c_stShift && r_cnt != c_shiftEnd) begin
      w_emit    = 1'b1;
      w_emitIdx = r_cnt + CW'(1);
    end
  end

  // With parity the last flag moves to the parity cycle.
  assign w_emitLast = !c_parityEn && (w_emitIdx == c_shiftEnd);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state             <= c_stIdle;
      r_cnt               <= '0;
      r_ptShadow          <= '0;
      r_tagShadow         <= '0;
`ifdef ASCON_SO_PARITY_EN
      r_ptPar             <= 1'b0;
      r_tagPar            <= 1'b0;
`endif
      load_readyxSO       <= 1'b1;
      decryption_readyxSO <= 1'b0;
      plain_textxSO       <= 1'b0;
      tagxSO              <= 1'b0;
      bit_validxSO        <= 1'b0;
      bit_lastxSO         <= 1'b0;
    end else begin
      plain_textxSO <= 1'b0;
      tagxSO        <= 1'b0;
      bit_validxSO  <= 1'b0;
      bit_lastxSO   <= 1'b0;

      case (r_state)
        c_stIdle: begin
          if (load_validxSI) begin
            r_ptShadow          <= plain_textxDI;
            r_tagShadow         <= tagxDI;
`ifdef ASCON_SO_PARITY_EN
            r_ptPar             <= ^plain_textxDI;
            r_tagPar            <= ^tagxDI;
`endif
            r_cnt               <= '0;
            r_state             <= c_stLead;
            load_readyxSO       <= 1'b0;
            decryption_readyxSO <= 1'b1;
          end
        end
        c_stLead: begin
          if (r_cnt == c_leadEnd) begin
            r_cnt   <= '0;
            r_state <= c_stShift;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        c_stShift: begin
          if (r_cnt == c_shiftEnd) begin
`ifdef ASCON_SO_PARITY_EN
            r_state       <= c_stPar;
            plain_textxSO <= r_ptPar;
            tagxSO        <= r_tagPar;
            bit_validxSO  <= 1'b1;
            bit_lastxSO   <= 1'b1;
`else
            r_state             <= c_stIdle;
            load_readyxSO       <= 1'b1;
            decryption_readyxSO <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef ASCON_SO_PARITY_EN
        c_stPar: begin
          r_state             <= c_stIdle;
          load_readyxSO       <= 1'b1;
          decryption_readyxSO <= 1'b0;
        end
`endif
        default: begin
          r_state             <= c_stIdle;
          load_readyxSO       <= 1'b1;
          decryption_readyxSO <= 1'b0;
        end
      endcase

      // Shadows shift right so the lane always reads bit 0; the shorter word
      // runs out into zero fill once its bits are exhausted.
      if (w_emit) begin
        plain_textxSO <= r_ptShadow[0];
        tagxSO        <= r_tagShadow[0];
        r_ptShadow    <= r_ptShadow >> 1;
        r_tagShadow   <= r_tagShadow >> 1;
        bit_validxSO  <= 1'b1;
        bit_lastxSO   <= w_emitLast;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_serial_unloader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_serial_unloader
// Purpose  : Self-checking bench for ascon_serial_unloader. A cycle-indexed
//            reference model derives every expected output from the frame
//            timing rules and the captured words. Build with or without
//            ASCON_SO_PARITY_EN; the model follows the same macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_serial_unloader;

  localparam int Y  = 80;
  localparam int TL = 128;
  localparam int LD = 2;
  localparam int MX = (Y >= TL) ? Y : TL;
`ifdef ASCON_SO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NEVER = -1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [Y-1:0]  plain_textxDI = '0;
  logic [TL-1:0] tagxDI = '0;
  logic          load_validxSI = 1'b0;
  logic          load_readyxSO;
  logic          decryption_readyxSO;
  logic          plain_textxSO;
  logic          tagxSO;
  logic          bit_validxSO;
  logic          bit_lastxSO;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ascon_serial_unloader #(.y(Y), .T(TL), .LEAD(LD)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .plain_textxDI       (plain_textxDI),
    .tagxDI              (tagxDI),
    .load_validxSI       (load_validxSI),
    .load_readyxSO       (load_readyxSO),
    .decryption_readyxSO (decryption_readyxSO),
    .plain_textxSO       (plain_textxSO),
    .tagxSO              (tagxSO),
    .bit_validxSO        (bit_validxSO),
    .bit_lastxSO         (bit_lastxSO)
  );

  localparam logic [5:0] IDLE_OUT = 6'b100000;

  function automatic logic [Y-1:0] randPt();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[Y-1:0];
  endfunction

  function automatic logic [TL-1:0] randTag();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output vector order: {load_ready, decryption_ready, pt, tag, valid, last}
  task automatic chk(input string name, input int idx, input logic [5:0] exp);
    logic [5:0] got;
    got = {load_readyxSO, decryption_readyxSO, plain_textxSO, tagxSO,
           bit_validxSO, bit_lastxSO};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %b expected %b", name, idx, got, exp);
    end
  endtask

  // Strobes one frame in at the current negedge and checks every cycle
  // until the unloader is back in IDLE. pokeK: bit index during which a
  // stray strobe is presented. abortK: bit index during which rst is pulled.
  task automatic frame(input string name, input logic [Y-1:0] pt,
                       input logic [TL-1:0] tg, input int pokeK,
                       input int abortK);
    int total;
    int k;
    logic [5:0] e;
    total = 1 + LD + MX + PAR;
    plain_textxDI = pt;
    tagxDI        = tg;
    load_validxSI = 1'b1;
    @(negedge clk);
    load_validxSI = 1'b0;
    for (int j = 1; j <= total; j++) begin
      k = j - LD - 2;
      if (k < 0)
        e = 6'b010000;
      else if (k < MX)
        e = {1'b0, 1'b1, (k < Y) ? pt[k] : 1'b0, (k < TL) ? tg[k] : 1'b0,
             1'b1, (k == MX - 1 && PAR == 0)};
      else
        e = {2'b01, ^pt, ^tg, 2'b11};
      chk(name, j, e);
      plain_textxDI = randPt();
      tagxDI        = randTag();
      load_validxSI = (k == pokeK);
      if (k == abortK) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        load_validxSI = 1'b0;
        chk({name, "_abort"}, k, IDLE_OUT);
        @(negedge clk);
        chk({name, "_abort_idle"}, k, IDLE_OUT);
        return;
      end
      @(negedge clk);
      load_validxSI = 1'b0;
    end
    chk({name, "_idle"}, total + 1, IDLE_OUT);
  endtask

  initial begin
    // Reset held for 3 cycles, then released with no strobe.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset", i, IDLE_OUT);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset", i, IDLE_OUT);
    end

    // Single set bits at opposite ends of the two words.
    frame("single_bits", 80'h1, {1'b1, 127'h0}, NEVER, NEVER);

    // All-ones plaintext, zero tag, stray strobe mid-frame must be ignored.
    frame("ones_poke", {Y{1'b1}}, '0, 40, NEVER);

    // Reset mid-frame, then a clean frame immediately after.
    frame("abort", randPt(), randTag(), NEVER, 50);
    frame("after_abort", 80'h1234, randTag(), NEVER, NEVER);

    // Back-to-back frames: each strobe lands in the first IDLE cycle.
    frame("b2b_a", randPt(), randTag(), NEVER, NEVER);
    frame("b2b_b", randPt(), randTag(), NEVER, NEVER);

    // Strobe coincident with reset: nothing must be captured.
    rst           = 1'b0;
    load_validxSI = 1'b1;
    plain_textxDI = randPt();
    tagxDI        = randTag();
    @(negedge clk);
    rst           = 1'b1;
    load_validxSI = 1'b0;
    chk("strobe_in_reset", 0, IDLE_OUT);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("strobe_in_reset", i, IDLE_OUT);
    end

    // Parity-distinguishing words (odd pt parity, even tag parity).
    frame("parity", 80'h7, 128'h3, NEVER, NEVER);

    // Random frames.
    for (int n = 0; n < 3; n++)
      frame("random", randPt(), randTag(), NEVER, NEVER);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
